// File: rtl/wash_pkg.sv
// Shared encodings for the multi-round washer controller: FSM states,
// motor drive codes and small decode helpers.
package wash_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FWD   = 3'd1;
    localparam logic [2:0] ST_STOP1 = 3'd2;
    localparam logic [2:0] ST_REV   = 3'd3;
    localparam logic [2:0] ST_STOP2 = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FWD   = ST_FWD,
        S_STOP1 = ST_STOP1,
        S_REV   = ST_REV,
        S_STOP2 = ST_STOP2,
        S_DONE  = ST_DONE
    } state_e;

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_FWD  = 2'b01;
    localparam logic [1:0] MOTOR_REV  = 2'b10;

    // Motor code a state drives when not paused.
    function automatic logic [1:0] motor_of(input state_e s);
        logic [1:0] m;
        m = MOTOR_STOP;
        case (s)
            S_FWD:   m = MOTOR_FWD;
            S_REV:   m = MOTOR_REV;
            default: m = MOTOR_STOP;
        endcase
        return m;
    endfunction

    // True for the four states in which a program is running.
    function automatic logic is_run(input state_e s);
        return (s == S_FWD) || (s == S_STOP1) || (s == S_REV) || (s == S_STOP2);
    endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Prescaler producing a one-clock tick every TICK_DIV enabled clocks.
// clr restarts the count from zero; en low freezes the count and the tick.
module wash_tick_gen #(
    parameter int TICK_DIV = 40000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at CNT_MAX while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == CNT_MAX);

endmodule

// File: rtl/wash_fsm_multi.sv
// Multi-round washer controller. Each round runs FWD, STOP1, REV, STOP2
// (stop phases skipped when STOP_T is 0). Supports pause, abort and reports
// busy, current round and seconds left in the current phase. All outputs
// are registered and computed from the next state.
module wash_fsm_multi
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 40000,
    parameter int TIME_W   = 8,
    parameter int ROUND_W  = 4,
    parameter int FWD_T    = 20,
    parameter int REV_T    = 20,
    parameter int STOP_T   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic [ROUND_W-1:0] rounds,
    output logic [1:0]         motor,
    output logic               compl_n,
    output logic               busy,
    output logic [ROUND_W-1:0] round_cnt,
    output logic [TIME_W-1:0]  remain,
    output logic [2:0]         state_dbg
);

    localparam logic [TIME_W-1:0] FWD_LEN  = TIME_W'(FWD_T);
    localparam logic [TIME_W-1:0] REV_LEN  = TIME_W'(REV_T);
    localparam logic [TIME_W-1:0] STOP_LEN = TIME_W'(STOP_T);
    localparam logic              SKIP_STOP = (STOP_T == 0);

    state_e             state_q, state_d;
    logic [TIME_W-1:0]  timer_q, timer_d;
    logic [ROUND_W-1:0] round_cnt_q, round_cnt_d;
    logic [ROUND_W-1:0] rounds_q, rounds_d;
    logic [1:0]         motor_q, motor_d;
    logic               compl_n_q, compl_n_d;
    logic               busy_q, busy_d;

    logic accept;
    logic tick;
    logic run_en;
    logic pause_hold;

    // Pause freezes the prescaler only while a program is running.
    assign run_en     = is_run(state_q) && !pause;
    assign pause_hold = is_run(state_q) && pause && !abort;

    wash_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (accept || abort),
        .en  (run_en),
        .tick(tick)
    );

    // Next state, phase timer and round counter; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        round_cnt_d = round_cnt_q;
        rounds_d    = rounds_q;
        accept      = 1'b0;
        if (abort) begin
            state_d     = S_IDLE;
            timer_d     = '0;
            round_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && (rounds != '0)) begin
                        accept      = 1'b1;
                        rounds_d    = rounds;
                        round_cnt_d = ROUND_W'(1);
                        state_d     = S_FWD;
                        timer_d     = FWD_LEN;
                    end
                end
                default: begin
                    if (tick) begin
                        if (timer_q != TIME_W'(1)) begin
                            timer_d = timer_q - 1'b1;
                        end else begin
                            // Phase ends: pick the next phase or close the round.
                            case (state_q)
                                S_FWD: begin
                                    state_d = SKIP_STOP ? S_REV : S_STOP1;
                                    timer_d = SKIP_STOP ? REV_LEN : STOP_LEN;
                                end
                                S_STOP1: begin
                                    state_d = S_REV;
                                    timer_d = REV_LEN;
                                end
                                S_REV: begin
                                    if (SKIP_STOP) begin
                                        state_d = S_STOP2;
                                    end else begin
                                        state_d = S_STOP2;
                                        timer_d = STOP_LEN;
                                    end
                                end
                                default: begin
                                    state_d = S_STOP2;
                                end
                            endcase
                            // End of round: from REV (stops skipped) or STOP2.
                            if ((state_q == S_STOP2) || ((state_q == S_REV) && SKIP_STOP)) begin
                                if (round_cnt_q == rounds_q) begin
                                    state_d = S_DONE;
                                    timer_d = '0;
                                end else begin
                                    round_cnt_d = round_cnt_q + 1'b1;
                                    state_d     = S_FWD;
                                    timer_d     = FWD_LEN;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Registered outputs decoded from the next state.
    always_comb begin
        motor_d   = pause_hold ? MOTOR_STOP : motor_of(state_d);
        compl_n_d = (state_d != S_DONE);
        busy_d    = is_run(state_d);
    end

    // State, timer, round and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            round_cnt_q <= '0;
            rounds_q    <= '0;
            motor_q     <= MOTOR_STOP;
            compl_n_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            round_cnt_q <= round_cnt_d;
            rounds_q    <= rounds_d;
            motor_q     <= motor_d;
            compl_n_q   <= compl_n_d;
            busy_q      <= busy_d;
        end
    end

    assign motor     = motor_q;
    assign compl_n   = compl_n_q;
    assign busy      = busy_q;
    assign round_cnt = round_cnt_q;
    assign remain    = timer_q;
    assign state_dbg = state_q;

endmodule
